// File: rtl/lcd_pkg.sv
// lcd_pkg: shared command codes and sequencer FSM encoding.
// No ports; imported by lcd_cmd_fifo and lcd_cmd_sequencer.
package lcd_pkg;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_WRITE = 3'd0;
  localparam logic [CMD_W-1:0] CMD_UP    = 3'd1;
  localparam logic [CMD_W-1:0] CMD_DOWN  = 3'd2;
  localparam logic [CMD_W-1:0] CMD_LEFT  = 3'd3;
  localparam logic [CMD_W-1:0] CMD_RIGHT = 3'd4;
  localparam logic [CMD_W-1:0] CMD_AVG   = 3'd5;
  localparam logic [CMD_W-1:0] CMD_MIRX  = 3'd6;
  localparam logic [CMD_W-1:0] CMD_MIRY  = 3'd7;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_READY,
    ST_GAP,
    ST_WAIT_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: show-ahead sync FIFO for command codes.
// Ports: clk, reset (sync, low), push/din, pop/head, full, empty, level.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [CMD_W-1:0]       din,
  input  logic                   pop,
  output logic [CMD_W-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case (1'b1)
        push && !pop: level <= level + 1'b1;
        pop && !push: level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign head  = mem[rp];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: queues host commands, issues them to the LCD controller.
// Ports: host_cmd/valid/ready in, lcd_busy/done in, cmd/cmd_valid out,
// seq_idle, fifo_level, frame_cnt, err_timeout. Option: LCD_SEQ_AUTO_WRITE_EN.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int WRITE_TIMEOUT = 200,
  parameter int ISSUE_GAP     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CMD_W-1:0]            host_cmd,
  input  logic                        host_valid,
  output logic                        host_ready,
  input  logic                        lcd_busy,
  input  logic                        lcd_done,
  output logic [CMD_W-1:0]            cmd,
  output logic                        cmd_valid,
  output logic                        seq_idle,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  frame_cnt,
  output logic                        err_timeout
);

  localparam int TW = $clog2(WRITE_TIMEOUT + 1);

  state_t           state;
  state_t           state_nx;
  logic [TW-1:0]    cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [CMD_W-1:0] head;
  logic             issue;
  logic [CMD_W-1:0] issue_cmd;

  // gated by reset so the port reads 0 while reset is held
  assign host_ready = reset && !full && (state != ST_ERROR);
  assign push       = host_valid && host_ready;
  assign seq_idle   = reset && empty && (state == ST_READY);

  lcd_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (host_cmd),
    .pop  (pop),
    .head (head),
    .full (full),
    .empty(empty),
    .level(fifo_level)
  );

`ifdef LCD_SEQ_AUTO_WRITE_EN
  logic       dirty;
  logic [3:0] idle_cnt;

  // dirty: a non-Write has issued since the last Write
  always_ff @(posedge clk) begin
    if (!reset) begin
      dirty    <= 1'b0;
      idle_cnt <= '0;
    end else begin
      if (issue) dirty <= (issue_cmd != CMD_WRITE);
      if (state == ST_READY && empty && !issue) begin
        if (idle_cnt != 4'd15) idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_BOOT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_BOOT:
        if (!lcd_busy) state_nx = ST_READY;
      ST_READY:
        if (issue)
          state_nx = (issue_cmd == CMD_WRITE) ? ST_WAIT_DONE : ST_GAP;
      ST_GAP:
        if (cnt == TW'(ISSUE_GAP)) state_nx = ST_READY;
      ST_WAIT_DONE:
        if (lcd_done)                          state_nx = ST_READY;
        else if (cnt == TW'(WRITE_TIMEOUT))    state_nx = ST_ERROR;
      ST_ERROR: ;
      default: state_nx = ST_BOOT;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    issue     = 1'b0;
    issue_cmd = head;
    if (state == ST_READY && !lcd_busy) begin
      if (!empty) begin
        pop   = 1'b1;
        issue = 1'b1;
      end
`ifdef LCD_SEQ_AUTO_WRITE_EN
      else if (dirty && idle_cnt == 4'd15) begin
        issue     = 1'b1;
        issue_cmd = CMD_WRITE;
      end
`endif
    end
  end

  // cnt restarts at 1 on every state change; shared by GAP and WAIT_DONE
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      cmd         <= '0;
      cmd_valid   <= 1'b0;
      frame_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      cmd_valid <= issue;
      if (issue) cmd <= issue_cmd;
      if (state != state_nx)
        cnt <= TW'(1);
      else if (state == ST_GAP || state == ST_WAIT_DONE)
        cnt <= cnt + 1'b1;
      if (state == ST_WAIT_DONE && lcd_done)
        frame_cnt <= frame_cnt + 1'b1;
      if (state == ST_WAIT_DONE && !lcd_done &&
          cnt == TW'(WRITE_TIMEOUT))
        err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: directed stimulus with a cmd scoreboard.
// Expected issues are queued by the stimulus, checked by a monitor.
module tb_lcd_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] host_cmd = '0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic       lcd_busy = 1'b1;
  logic       lcd_done = 1'b0;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       seq_idle;
  logic [2:0] fifo_level;
  logic [7:0] frame_cnt;
  logic       err_timeout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit quiet = 1'b0;
  logic [2:0] exp_q[$];
  int issue_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_cmd_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .host_cmd   (host_cmd),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .lcd_busy   (lcd_busy),
    .lcd_done   (lcd_done),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .seq_idle   (seq_idle),
    .fifo_level (fifo_level),
    .frame_cnt  (frame_cnt),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // monitor: every issue must match the head of the expected queue
  always @(negedge clk) begin
    if (reset && cmd_valid) begin
      issue_cyc.push_back(cyc);
      if (quiet) begin
        checks++;
        errors++;
        $display("FAIL quiet_issue: got cmd %0d at cycle %0d want none",
                 cmd, cyc);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_issue: got cmd %0d want none", cmd);
      end else begin
        chk("issue_cmd", int'(cmd), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b0;
    host_valid = 1'b0;
    lcd_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_host_ready", int'(host_ready), 0);
    chk("rst_seq_idle", int'(seq_idle), 0);
    chk("rst_fifo_level", int'(fifo_level), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_err_timeout", int'(err_timeout), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    quiet = 1'b0;
    exp_q.delete();
    issue_cyc.delete();
  endtask

  task automatic push(input logic [2:0] c, input bit exp);
    int n = 0;
    host_cmd = c;
    host_valid = 1'b1;
    @(negedge clk);
    while (!host_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!host_ready) chk("push_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    if (exp) exp_q.push_back(c);
  endtask

  task automatic wait_valid(input string name, input int lim);
    int n = 0;
    @(negedge clk);
    while (!cmd_valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: got no cmd_valid want one within %0d", name, lim);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;

    // 1: queue during boot load, then issue with one idle cycle between
    apply_reset();
    quiet = 1'b1;
    push(3'd1, 1'b1);
    push(3'd3, 1'b1);
    push(3'd5, 1'b1);
    @(negedge clk);
    chk("t1_level_full3", int'(fifo_level), 3);
    chk("t1_idle_boot", int'(seq_idle), 0);
    repeat (58) @(posedge clk);
    #1;
    lcd_busy = 1'b0;
    quiet = 1'b0;
    wait_valid("t1_first", 10);
    repeat (8) @(negedge clk);
    chk("t1_issue_count", issue_cyc.size(), 3);
    if (issue_cyc.size() == 3) begin
      chk("t1_gap_a", issue_cyc[1] - issue_cyc[0], 2);
      chk("t1_gap_b", issue_cyc[2] - issue_cyc[1], 2);
    end
    chk("t1_level_end", int'(fifo_level), 0);
    chk("t1_idle_end", int'(seq_idle), 1);

    // 2: overfill while busy; fifth accepted after the first pop
    apply_reset();
    lcd_busy = 1'b1;
    quiet = 1'b1;
    push(3'd1, 1'b1);
    push(3'd2, 1'b1);
    push(3'd3, 1'b1);
    push(3'd4, 1'b1);
    @(negedge clk);
    chk("t2_ready_full", int'(host_ready), 0);
    chk("t2_level_full", int'(fifo_level), 4);
    fork
      push(3'd6, 1'b1);
      begin
        repeat (5) @(posedge clk);
        #1;
        lcd_busy = 1'b0;
        quiet = 1'b0;
      end
    join
    repeat (14) @(negedge clk);
    chk("t2_sb_drained", exp_q.size(), 0);
    chk("t2_level_end", int'(fifo_level), 0);

    // 3: Write acknowledged 66 cycles later; Up waits for it
    apply_reset();
    push(3'd0, 1'b1);
    push(3'd1, 1'b1);
    wait_valid("t3_write", 10);
    @(posedge clk);
    #1;
    quiet = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    lcd_done = 1'b1;
    quiet = 1'b0;
    @(posedge clk);
    #1;
    lcd_done = 1'b0;
    @(negedge clk);
    chk("t3_frame", int'(frame_cnt), 1);
    chk("t3_level_held", int'(fifo_level), 1);
    wait_valid("t3_up", 5);
    repeat (3) @(negedge clk);
    chk("t3_idle", int'(seq_idle), 1);
    chk("t3_sb_drained", exp_q.size(), 0);

    // 4: Write never acknowledged -> timeout and lockout
    apply_reset();
    push(3'd0, 1'b1);
    push(3'd3, 1'b0);
    wait_valid("t4_write", 10);
    t0 = cyc;
    @(posedge clk);
    #1;
    quiet = 1'b1;
    n = 0;
    @(negedge clk);
    while (!err_timeout && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t4_timeout_cycle", cyc - t0, 200);
    chk("t4_err", int'(err_timeout), 1);
    chk("t4_ready", int'(host_ready), 0);
    chk("t4_level", int'(fifo_level), 1);
    repeat (20) @(negedge clk);
    chk("t4_level_kept", int'(fifo_level), 1);
    chk("t4_frame", int'(frame_cnt), 0);

    // 5: reset during WAIT_DONE with two commands queued
    apply_reset();
    lcd_busy = 1'b1;
    push(3'd0, 1'b1);
    push(3'd0, 1'b1);
    push(3'd2, 1'b0);
    push(3'd3, 1'b0);
    lcd_busy = 1'b0;
    wait_valid("t5_w1", 10);
    repeat (5) @(posedge clk);
    #1;
    lcd_done = 1'b1;
    @(posedge clk);
    #1;
    lcd_done = 1'b0;
    wait_valid("t5_w2", 10);
    @(posedge clk);
    #1;
    quiet = 1'b1;
    @(negedge clk);
    chk("t5_level_pre", int'(fifo_level), 2);
    chk("t5_frame_pre", int'(frame_cnt), 1);
    @(posedge clk);
    #1;
    apply_reset();

    // 6: single non-Write then idle
    push(3'd4, 1'b1);
`ifdef LCD_SEQ_AUTO_WRITE_EN
    exp_q.push_back(3'd0);
`endif
    wait_valid("t6_right", 10);
    @(posedge clk);
    #1;
`ifndef LCD_SEQ_AUTO_WRITE_EN
    quiet = 1'b1;
`endif
    repeat (40) @(negedge clk);
    chk("t6_sb_drained", exp_q.size(), 0);
    chk("t6_err", int'(err_timeout), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
